// File: rtl/pong_serve_rng.sv
// Random serve generator: free-running 16-bit Fibonacci LFSR plus a small FSM that
// turns an LFSR snapshot into a serve direction and a start row folded into 0..Y_MAX.
module pong_serve_rng #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter int                Y_W    = 10,
  parameter int                Y_MAX  = 440
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              serve_req,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              rnd_bit,
  output logic              busy,
  output logic              serve_valid,
  output logic              dir_x,
  output logic              dir_y,
  output logic [Y_W-1:0]    y_start
);

  typedef enum logic {
    IDLE,
    REDUCE
  } state_t;

  // One extra bit on the remainder keeps the compare/subtract free of wrap-around.
  localparam logic [Y_W:0] REM_LIMIT = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0] REM_MOD   = (Y_W+1)'(Y_MAX + 1);

  state_t            state_reg;
  logic [LFSR_W-1:0] lfsr_reg;
  logic [LFSR_W-1:0] lfsr_next;
  logic [LFSR_W-1:0] lfsr_step;
  logic              fb;
  logic [Y_W:0]      rem_reg;
  logic              dx_reg;
  logic              dy_reg;

  assign fb        = lfsr_reg[LFSR_W-1] ^ lfsr_reg[LFSR_W-3] ^ lfsr_reg[LFSR_W-4] ^ lfsr_reg[LFSR_W-6];
  assign lfsr_step = {lfsr_reg[LFSR_W-2:0], fb};

  // A zero seed would lock the LFSR, so it is replaced by the reset seed.
  always_comb begin
    lfsr_next = lfsr_step;
    if (seed_load) begin
      lfsr_next = (seed_in != '0) ? seed_in : SEED;
    end
  end

  assign rnd_bit = lfsr_reg[LFSR_W-1];
  assign busy    = (state_reg == REDUCE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg    <= SEED;
      state_reg   <= IDLE;
      rem_reg     <= '0;
      dx_reg      <= 1'b0;
      dy_reg      <= 1'b0;
      serve_valid <= 1'b0;
      dir_x       <= 1'b0;
      dir_y       <= 1'b0;
      y_start     <= '0;
    end else begin
      lfsr_reg    <= lfsr_next;
      serve_valid <= 1'b0;
      if (state_reg == IDLE) begin
        // Snapshot is the pre-advance value, even when a seed is loaded this edge.
        if (serve_req) begin
          dx_reg    <= lfsr_reg[0];
          dy_reg    <= lfsr_reg[1];
          rem_reg   <= {1'b0, lfsr_reg[LFSR_W-1 -: Y_W]};
          state_reg <= REDUCE;
        end
      end else begin
        if (rem_reg > REM_LIMIT) begin
          rem_reg <= rem_reg - REM_MOD;
        end else begin
          y_start     <= rem_reg[Y_W-1:0];
          dir_x       <= dx_reg;
          dir_y       <= dy_reg;
          serve_valid <= 1'b1;
          state_reg   <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pong_serve_rng.sv
// Scoreboard bench for pong_serve_rng: driver owns a cycle-level reference model and
// queues expected serves; a monitor pops them whenever serve_valid is seen.
module tb_pong_serve_rng;

  localparam int LFSR_W = 16;
  localparam int SEED   = 'hACE1;
  localparam int Y_W    = 10;
  localparam int Y_MAX  = 440;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              serve_req = 1'b0;
  logic              seed_load = 1'b0;
  logic [LFSR_W-1:0] seed_in = '0;
  logic              rnd_bit;
  logic              busy;
  logic              serve_valid;
  logic              dir_x;
  logic              dir_y;
  logic [Y_W-1:0]    y_start;

  pong_serve_rng #(
    .LFSR_W(LFSR_W), .SEED(16'hACE1), .Y_W(Y_W), .Y_MAX(Y_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .serve_req(serve_req), .seed_load(seed_load),
    .seed_in(seed_in), .rnd_bit(rnd_bit), .busy(busy), .serve_valid(serve_valid),
    .dir_x(dir_x), .dir_y(dir_y), .y_start(y_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    int dx;
    int dy;
  } serve_t;

  serve_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state, written only by the driver.
  int m_q        = SEED;
  int m_busy_cyc = 0;
  int m_valid    = 0;

  int nvalid = 0;
  int hold_y = 0;
  int hold_dx = 0;
  int hold_dy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int lfsr_next(input int q);
    int t;
    int p;
    t = q & 'hB400;
    p = 0;
    for (int i = 0; i < 16; i++) p ^= (t >> i) & 1;
    return ((q << 1) | p) & 'hFFFF;
  endfunction

  // Advance one clock; the model consumes the inputs that were present at the edge.
  task automatic step();
    int s;
    int r0;
    serve_t e;
    @(posedge clk);
    m_valid = 0;
    if (m_busy_cyc != 0) begin
      m_busy_cyc--;
      if (m_busy_cyc == 0) m_valid = 1;
    end else if (serve_req) begin
      s    = m_q;
      r0   = (s >> (LFSR_W - Y_W)) & ((1 << Y_W) - 1);
      e.y  = r0 % (Y_MAX + 1);
      e.dx = s & 1;
      e.dy = (s >> 1) & 1;
      exp_q.push_back(e);
      m_busy_cyc = r0 / (Y_MAX + 1) + 1;
    end
    if (seed_load) m_q = (seed_in != 0) ? int'(seed_in) : SEED;
    else           m_q = lfsr_next(m_q);
    #1;
  endtask

  task automatic model_reset();
    m_q        = SEED;
    m_busy_cyc = 0;
    m_valid    = 0;
  endtask

  // Monitor: per-cycle checks plus scoreboard pop on every serve_valid.
  initial begin
    serve_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        hold_y = 0; hold_dx = 0; hold_dy = 0;
      end else begin
        check("rnd_bit", 32'(rnd_bit), 32'((m_q >> 15) & 1));
        check("busy", 32'(busy), 32'(m_busy_cyc != 0));
        check("serve_valid", 32'(serve_valid), 32'(m_valid));
        if (serve_valid === 1'b1) begin
          nvalid++;
          if (exp_q.size() == 0) begin
            check("unexpected_serve", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            hold_y = e.y; hold_dx = e.dx; hold_dy = e.dy;
          end
        end
        check("y_start", 32'(y_start), 32'(hold_y));
        check("dir_x", 32'(dir_x), 32'(hold_dx));
        check("dir_y", 32'(dir_y), 32'(hold_dy));
      end
    end
  end

  task automatic serve_test(input logic [15:0] seed, input bit pulse,
                            input int ey, input int edx, input int edy, input int ebusy);
    int nb;
    int v0;
    seed_load = 1'b1; seed_in = seed; serve_req = 1'b0;
    step();
    seed_load = 1'b0; serve_req = 1'b1;
    step();
    serve_req = 1'b0;
    nb = 0;
    v0 = nvalid;
    for (int i = 0; i < 6; i++) begin
      if (busy === 1'b1) nb++;
      serve_req = (pulse && i == 1);
      step();
    end
    serve_req = 1'b0;
    check("busy_cycles", 32'(nb), 32'(ebusy));
    check("serve_count", 32'(nvalid - v0), 32'd1);
    check("dir_y_const", 32'(y_start), 32'(ey));
    check("dx_const", 32'(dir_x), 32'(edx));
    check("dy_const", 32'(dir_y), 32'(edy));
  endtask

  initial begin
    int v0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rnd_bit", 32'(rnd_bit), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(serve_valid), 32'd0);
    check("rst_y", 32'(y_start), 32'd0);
    check("rst_dirs", {30'd0, dir_x, dir_y}, 32'd0);
    rst_n = 1'b1;
    step();
    check("first_step_q", 32'(dut.lfsr_reg), 32'h59C3);
    check("first_step_rnd", 32'(rnd_bit), 32'd0);

    serve_test(16'hFFFF, 1'b0, 141, 1, 1, 3);
    serve_test(16'hFFFF, 1'b1, 141, 1, 1, 3);
    serve_test(16'h6E02, 1'b0, 440, 0, 1, 1);

    // Reset in the middle of a reduction aborts the serve.
    seed_load = 1'b1; seed_in = 16'hFFFF;
    step();
    seed_load = 1'b0; serve_req = 1'b1;
    step();
    serve_req = 1'b0;
    step();
    v0 = nvalid;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(serve_valid), 32'd0);
    check("midrst_y", 32'(y_start), 32'd0);
    check("midrst_q", 32'(dut.lfsr_reg), 32'hACE1);
    rst_n = 1'b1;
    repeat (6) step();
    check("midrst_no_serve", 32'(nvalid - v0), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      serve_req = ($urandom_range(0, 2) == 0);
      seed_load = ($urandom_range(0, 31) == 0);
      seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
    end_placeholder_guard:
      step();
    end
    serve_req = 1'b0; seed_load = 1'b0;
    repeat (6) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Zero seed substitutes the reset seed; the full period returns to it.
    seed_load = 1'b1; seed_in = 16'h0;
    step();
    seed_load = 1'b0;
    check("zero_seed_q", 32'(dut.lfsr_reg), 32'hACE1);
    repeat (65535) step();
    check("period_q", 32'(dut.lfsr_reg), 32'hACE1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
